// File: rtl/commands_pkg.sv
// Bus command encoding shared by the cache controllers and the snoopy bus.
// NONE is encoded as zero so that cleared buses read as idle.
package commands;

    typedef enum logic [2:0] {
        NONE               = 3'd0,
        BUS_READ           = 3'd1,
        BUS_READ_EXCLUSIVE = 3'd2,
        BUS_INVALIDATE     = 3'd3,
        BUS_WRITEBACK      = 3'd4
    } Command;

endpackage

// File: rtl/snoopy_bus_arbiter_pkg.sv
// Types and default sizes for the snoopy bus arbiter.
package snoopy_bus_arbiter_types;
    import commands::*;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } ArbiterState;

    localparam int ADDRESS_WIDTH    = 8;
    localparam int DATA_WIDTH       = 8;
    localparam int NUMBER_OF_CACHES = 4;

endpackage

// File: rtl/snoopy_bus_arbiter_picker.sv
// bus_priority_picker: finds the first set request bit, scanning upward from
// startIndex with wrap-around. Purely combinational.
module bus_priority_picker #(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int INDEX_WIDTH      = 2
) (
    input  logic [NUMBER_OF_CACHES-1:0] request,
    input  logic [INDEX_WIDTH-1:0]      startIndex,
    output logic [INDEX_WIDTH-1:0]      winner,
    output logic                        valid
);

    // Wrap-around scan; the first hit locks in the winner.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUMBER_OF_CACHES; i++) begin
            int idx;
            idx = (int'(startIndex) + i) % NUMBER_OF_CACHES;
            if (!valid && request[idx]) begin
                winner = INDEX_WIDTH'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// snoopy_bus_arbiter: grants the shared snoopy bus to one cache controller at
// a time, muxes the owner onto the memory port, broadcasts its command to the
// other snoopers and gathers their invalidate acknowledgements.
// Build option: SNOOPY_BUS_ARBITER_FIXED_PRIORITY_EN selects lowest-index-wins
// arbitration instead of round-robin.
module snoopy_bus_arbiter
    import commands::*;
    import snoopy_bus_arbiter_types::*;
#(
    parameter int ADDRESS_WIDTH    = snoopy_bus_arbiter_types::ADDRESS_WIDTH,
    parameter int DATA_WIDTH       = snoopy_bus_arbiter_types::DATA_WIDTH,
    parameter int NUMBER_OF_CACHES = snoopy_bus_arbiter_types::NUMBER_OF_CACHES
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUMBER_OF_CACHES-1:0] request,
    output logic [NUMBER_OF_CACHES-1:0] grant,
    input  Command                      cpuCommandOut [NUMBER_OF_CACHES],
    input  logic [ADDRESS_WIDTH-1:0]    cpuAddress    [NUMBER_OF_CACHES],
    input  logic [DATA_WIDTH-1:0]       cpuDataOut    [NUMBER_OF_CACHES],
    input  logic [NUMBER_OF_CACHES-1:0] cpuReadEnabled,
    input  logic [NUMBER_OF_CACHES-1:0] cpuWriteEnabled,
    output logic [DATA_WIDTH-1:0]       cpuDataIn,
    output logic [NUMBER_OF_CACHES-1:0] cpuFunctionComplete,
    output logic [NUMBER_OF_CACHES-1:0] cpuIsInvalidated,
    output Command                      snoopyCommandIn [NUMBER_OF_CACHES],
    input  logic [NUMBER_OF_CACHES-1:0] snoopyIsInvalidated,
    output logic [ADDRESS_WIDTH-1:0]    memoryAddress,
    output logic [DATA_WIDTH-1:0]       memoryDataOut,
    output logic                        memoryReadEnabled,
    output logic                        memoryWriteEnabled,
    input  logic [DATA_WIDTH-1:0]       memoryDataIn,
    input  logic                        memoryFunctionComplete
);

    localparam int INDEX_WIDTH = (NUMBER_OF_CACHES > 1) ? $clog2(NUMBER_OF_CACHES) : 1;

    ArbiterState            state, nextState;
    logic [INDEX_WIDTH-1:0] owner, winner, startIndex;
    logic                   winnerValid;
    logic                   ackReg, ackNext;
    logic                   allSnoopersAcked;
    logic                   ownerReleasing;

    assign ownerReleasing = (state == OWNED) && !request[owner];

`ifdef SNOOPY_BUS_ARBITER_FIXED_PRIORITY_EN
    assign startIndex = '0;
`else
    logic [INDEX_WIDTH-1:0] lastOwner;

    // Remember the last owner so the next search starts just after it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)               lastOwner <= INDEX_WIDTH'(NUMBER_OF_CACHES - 1);
        else if (ownerReleasing) lastOwner <= owner;
    end

    assign startIndex = (lastOwner == INDEX_WIDTH'(NUMBER_OF_CACHES - 1)) ? '0 : lastOwner + 1'b1;
`endif

    bus_priority_picker #(
        .NUMBER_OF_CACHES (NUMBER_OF_CACHES),
        .INDEX_WIDTH      (INDEX_WIDTH)
    ) picker (
        .request    (request),
        .startIndex (startIndex),
        .winner     (winner),
        .valid      (winnerValid)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Latch the winner when the bus is handed out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                owner <= '0;
        else if ((state == IDLE) && winnerValid)  owner <= winner;
    end

    // Invalidate acknowledge register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ackReg <= 1'b0;
        else       ackReg <= ackNext;
    end

    // Next-state logic: grant on any request, release when the owner drops its request.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (winnerValid)    nextState = OWNED;
            OWNED:   if (!request[owner]) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Every snooper except the owner must acknowledge; the owner's own ack is ignored.
    always_comb begin
        allSnoopersAcked = 1'b1;
        for (int j = 0; j < NUMBER_OF_CACHES; j++) begin
            if ((INDEX_WIDTH'(j) != owner) && !snoopyIsInvalidated[j]) allSnoopersAcked = 1'b0;
        end
    end

    // Ack sets once all snoopers agree and holds while the invalidate persists.
    always_comb begin
        ackNext = 1'b0;
        if ((state == OWNED) && request[owner] && (cpuCommandOut[owner] == BUS_INVALIDATE))
            ackNext = ackReg | allSnoopersAcked;
    end

    // Output logic: everything quiet in IDLE, owner muxed through in OWNED.
    always_comb begin
        grant               = '0;
        cpuDataIn           = '0;
        cpuFunctionComplete = '0;
        cpuIsInvalidated    = '0;
        memoryAddress       = '0;
        memoryDataOut       = '0;
        memoryReadEnabled   = 1'b0;
        memoryWriteEnabled  = 1'b0;
        for (int j = 0; j < NUMBER_OF_CACHES; j++) snoopyCommandIn[j] = NONE;
        if (state == OWNED) begin
            grant[owner]               = 1'b1;
            memoryAddress              = cpuAddress[owner];
            memoryDataOut              = cpuDataOut[owner];
            memoryReadEnabled          = cpuReadEnabled[owner];
            memoryWriteEnabled         = cpuWriteEnabled[owner] && !cpuReadEnabled[owner];
            cpuDataIn                  = memoryDataIn;
            cpuFunctionComplete[owner] = memoryFunctionComplete;
            cpuIsInvalidated[owner]    = ackReg;
            for (int j = 0; j < NUMBER_OF_CACHES; j++) begin
                if (INDEX_WIDTH'(j) != owner) snoopyCommandIn[j] = cpuCommandOut[owner];
            end
        end
    end

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed bench for snoopy_bus_arbiter (4 caches, 8-bit address/data).
module tb_snoopy_bus_arbiter;
    import commands::*;

    logic         clock;
    logic         reset;
    logic [3:0]   request;
    logic [3:0]   grant;
    Command       cpuCommandOut [4];
    logic [7:0]   cpuAddress    [4];
    logic [7:0]   cpuDataOut    [4];
    logic [3:0]   cpuReadEnabled;
    logic [3:0]   cpuWriteEnabled;
    logic [7:0]   cpuDataIn;
    logic [3:0]   cpuFunctionComplete;
    logic [3:0]   cpuIsInvalidated;
    Command       snoopyCommandIn [4];
    logic [3:0]   snoopyIsInvalidated;
    logic [7:0]   memoryAddress;
    logic [7:0]   memoryDataOut;
    logic         memoryReadEnabled;
    logic         memoryWriteEnabled;
    logic [7:0]   memoryDataIn;
    logic         memoryFunctionComplete;

    int checkCount = 0;
    int passCount  = 0;

    snoopy_bus_arbiter dut (
        .clock                  (clock),
        .reset                  (reset),
        .request                (request),
        .grant                  (grant),
        .cpuCommandOut          (cpuCommandOut),
        .cpuAddress             (cpuAddress),
        .cpuDataOut             (cpuDataOut),
        .cpuReadEnabled         (cpuReadEnabled),
        .cpuWriteEnabled        (cpuWriteEnabled),
        .cpuDataIn              (cpuDataIn),
        .cpuFunctionComplete    (cpuFunctionComplete),
        .cpuIsInvalidated       (cpuIsInvalidated),
        .snoopyCommandIn        (snoopyCommandIn),
        .snoopyIsInvalidated    (snoopyIsInvalidated),
        .memoryAddress          (memoryAddress),
        .memoryDataOut          (memoryDataOut),
        .memoryReadEnabled      (memoryReadEnabled),
        .memoryWriteEnabled     (memoryWriteEnabled),
        .memoryDataIn           (memoryDataIn),
        .memoryFunctionComplete (memoryFunctionComplete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkSnoopers(input string tag, input Command e0, input Command e1,
                                 input Command e2, input Command e3);
        check({tag, "_snoop0"}, snoopyCommandIn[0], e0);
        check({tag, "_snoop1"}, snoopyCommandIn[1], e1);
        check({tag, "_snoop2"}, snoopyCommandIn[2], e2);
        check({tag, "_snoop3"}, snoopyCommandIn[3], e3);
    endtask

`ifdef SNOOPY_BUS_ARBITER_FIXED_PRIORITY_EN
    localparam int ROUNDS = 3;
`else
    localparam int ROUNDS = 5;
`endif

    logic [3:0] expectedGrant;

    initial begin
        reset = 1'b1;
        request = '0;
        cpuReadEnabled = '0;
        cpuWriteEnabled = '0;
        snoopyIsInvalidated = '0;
        memoryDataIn = '0;
        memoryFunctionComplete = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpuCommandOut[i] = NONE;
            cpuAddress[i]    = '0;
            cpuDataOut[i]    = '0;
        end

        // Reset state
        #12 reset = 1'b0;
        tick();
        check("reset_grant", grant, 4'b0000);
        check("reset_memRead", memoryReadEnabled, 1'b0);
        check("reset_memWrite", memoryWriteEnabled, 1'b0);
        check("reset_cpuInv", cpuIsInvalidated, 4'b0000);
        check("reset_cpuDone", cpuFunctionComplete, 4'b0000);
        checkSnoopers("reset", NONE, NONE, NONE, NONE);

        // Grant 0, release, then 2 after a turnaround cycle
        request = 4'b0101;
        tick();
        check("first_grant", grant, 4'b0001);
        request = 4'b0100;
        tick();
        check("release_grant", grant, 4'b0000);
        tick();
        check("second_grant", grant, 4'b0100);
        request = 4'b0000;
        tick();
        check("second_release", grant, 4'b0000);

        // Restore lastOwner, then all four compete continuously
        reset = 1'b1;
        #2 reset = 1'b0;
        request = 4'b1111;
        for (int k = 0; k < ROUNDS; k++) begin
`ifdef SNOOPY_BUS_ARBITER_FIXED_PRIORITY_EN
            expectedGrant = 4'b0001;
`else
            expectedGrant = 4'b0001 << (k % 4);
`endif
            tick();
            check($sformatf("rr_grant%0d", k), grant, expectedGrant);
            tick();
            tick();
            check($sformatf("rr_hold%0d", k), grant, expectedGrant);
            request = request & ~expectedGrant;
            tick();
            check($sformatf("rr_release%0d", k), grant, 4'b0000);
            request = 4'b1111;
        end
        request = 4'b0000;
        tick();

        // Owner 1 invalidates 0x3C
        request = 4'b0010;
        tick();
        check("inv_grant", grant, 4'b0010);
        cpuCommandOut[1] = BUS_INVALIDATE;
        cpuAddress[1]    = 8'h3C;
        #1;
        check("inv_addr", memoryAddress, 8'h3C);
        checkSnoopers("inv", BUS_INVALIDATE, NONE, BUS_INVALIDATE, BUS_INVALIDATE);
        snoopyIsInvalidated = 4'b0101;
        tick();
        check("inv_partial", cpuIsInvalidated, 4'b0000);
        snoopyIsInvalidated = 4'b0111;
        tick();
        check("inv_owner_ack_ignored", cpuIsInvalidated, 4'b0000);
        snoopyIsInvalidated = 4'b1101;
        #1;
        check("inv_not_yet", cpuIsInvalidated, 4'b0000);
        tick();
        check("inv_acked", cpuIsInvalidated, 4'b0010);
        cpuCommandOut[1] = NONE;
        snoopyIsInvalidated = 4'b0000;
        tick();
        check("inv_cleared", cpuIsInvalidated, 4'b0000);
        request = 4'b0000;
        tick();
        check("inv_release", grant, 4'b0000);

        // Owner 2 reads 0xA5 with a competing write strobe
        request = 4'b0100;
        tick();
        check("rd_grant", grant, 4'b0100);
        cpuAddress[2]      = 8'hA5;
        cpuDataOut[2]      = 8'h77;
        cpuReadEnabled[2]  = 1'b1;
        cpuWriteEnabled[2] = 1'b1;
        cpuAddress[0]      = 8'h11;
        cpuReadEnabled[0]  = 1'b1;
        #1;
        check("rd_addr", memoryAddress, 8'hA5);
        check("rd_dataOut", memoryDataOut, 8'h77);
        check("rd_strobe", memoryReadEnabled, 1'b1);
        check("rd_write_suppressed", memoryWriteEnabled, 1'b0);
        check("rd_not_done", cpuFunctionComplete, 4'b0000);
        tick();
        tick();
        tick();
        memoryDataIn = 8'h5A;
        memoryFunctionComplete = 1'b1;
        #1;
        check("rd_data", cpuDataIn, 8'h5A);
        check("rd_done", cpuFunctionComplete, 4'b0100);
        memoryFunctionComplete = 1'b0;
        cpuReadEnabled[2] = 1'b0;
        #1;
        check("wr_strobe", memoryWriteEnabled, 1'b1);
        cpuWriteEnabled[2] = 1'b0;
        cpuReadEnabled[0]  = 1'b0;
        request = 4'b0000;
        tick();
        check("rd_release_strobe", memoryReadEnabled, 1'b0);

        // Asynchronous reset while cache 3 owns the bus
        request = 4'b1000;
        tick();
        check("rst_grant", grant, 4'b1000);
        cpuReadEnabled[3] = 1'b1;
        #1;
        check("rst_strobe_before", memoryReadEnabled, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("rst_grant_drop", grant, 4'b0000);
        check("rst_strobe_drop", memoryReadEnabled, 1'b0);
        reset = 1'b0;
        cpuReadEnabled[3] = 1'b0;
        request = 4'b1001;
        tick();
        check("rst_regrant", grant, 4'b0001);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
